// File: rtl/sdr_word_streamer.sv
// sdr_word_streamer
//   Captures the SDRAM read master's burst buffer on a load pulse and streams
//   it out one word per beat over a valid/ready interface.
//
// Ports:
//   clkin        clock, all logic on posedge
//   sdr_reset    asynchronous active-high reset
//   load         capture request (single-cycle pulse from read-end)
//   load_data    burst buffer, word k at [WORD_WIDTH*k +: WORD_WIDTH]
//   load_nelems  number of valid words in load_data (clamped to MAX_WORDS)
//   load_ready   high while idle and able to accept a load
//   flush        abort the current stream (no done pulse)
//   out_valid    output word valid
//   out_ready    consumer accepts the word
//   out_data     current word
//   out_index    index of current word in the buffer
//   out_last     current word is the final word
//   done         one-cycle pulse after the final handshake (or an empty load)
//   err_clamp    sticky: a load requested more than MAX_WORDS words
//   err_drop     sticky: a load arrived while busy and was ignored
module sdr_word_streamer #(
   parameter int BUF_WIDTH  = 2048,
   parameter int WORD_WIDTH = 32,
   parameter int MAX_WORDS  = BUF_WIDTH / WORD_WIDTH,
   parameter int IDX_WIDTH  = $clog2(MAX_WORDS)
) (
   input  logic                  clkin,
   input  logic                  sdr_reset,
   input  logic                  load,
   input  logic [BUF_WIDTH-1:0]  load_data,
   input  logic [29:0]           load_nelems,
   output logic                  load_ready,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_WIDTH-1:0] out_data,
   output logic [IDX_WIDTH-1:0]  out_index,
   output logic                  out_last,
   output logic                  done,
   output logic                  err_clamp,
   output logic                  err_drop
);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                state;
   logic [BUF_WIDTH-1:0]  buffer;
   // One extra bit so a full buffer (MAX_WORDS) is representable.
   logic [IDX_WIDTH:0]    count;

   // Word-addressable view of the captured buffer.
   logic [WORD_WIDTH-1:0] buf_word [MAX_WORDS];

   genvar gi;
   generate
      for (gi = 0; gi < MAX_WORDS; gi++) begin : g_word
         assign buf_word[gi] = buffer[gi*WORD_WIDTH +: WORD_WIDTH];
      end
   endgenerate

   logic                  over_max;
   logic [IDX_WIDTH:0]    load_count;
   logic [IDX_WIDTH-1:0]  next_index;
   logic                  next_last;

   assign over_max   = load_nelems > 30'(MAX_WORDS);
   assign load_count = over_max ? (IDX_WIDTH+1)'(MAX_WORDS) : load_nelems[IDX_WIDTH:0];
   // out_index doubles as the stream position; it only advances while not last,
   // so it never reaches count.
   assign next_index = out_index + 1'b1;
   assign next_last  = ({1'b0, next_index} == (count - 1'b1));

   assign load_ready = (state == IDLE);

   always_ff @(posedge clkin or posedge sdr_reset) begin
      if (sdr_reset) begin
         state     <= IDLE;
         buffer    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         err_clamp <= 1'b0;
         err_drop  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // A flush while idle is meaningless; load takes effect regardless.
               if (load) begin
                  buffer <= load_data;
                  count  <= load_count;
                  if (over_max)
                     err_clamp <= 1'b1;
                  if (load_count == '0) begin
                     done <= 1'b1;
                  end else begin
                     state     <= STREAM;
                     out_valid <= 1'b1;
                     out_data  <= load_data[WORD_WIDTH-1:0];
                     out_index <= '0;
                     out_last  <= (load_count == (IDX_WIDTH+1)'(1));
                  end
               end
            end
            STREAM: begin
               // Busy: the load is dropped, including on the final-handshake cycle.
               if (load)
                  err_drop <= 1'b1;
               if (flush) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end else if (out_ready) begin
                  if (out_last) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     out_index <= next_index;
                     out_data  <= buf_word[next_index];
                     out_last  <= next_last;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
